grid_clb_nk: RTL and testbench



---
 rtl/clb_pkg.sv | 45 ++++
 rtl/clb_ble.sv | 60 ++++++
 rtl/grid_clb_nk.sv | 86 ++++++++
 tb/tb_grid_clb_nk.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clb_pkg.sv
// Shared sizing helpers and config field offsets for grid_clb_nk.
// Widths are derived from the tile parameters via constant functions.
package clb_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int sel_w(input int num_in,
                               input int num_ble);
    return clog2(num_in + num_ble);
  endfunction

  function automatic int ble_bits(input int k,
                                  input int sw);
    return k * sw + (1 << k) + 2;
  endfunction

  function automatic int cfg_bits(input int nb,
                                  input int bb);
    return nb * bb;
  endfunction

  localparam int OFF_SEL = 0;

  function automatic int off_lut(input int k,
                                 input int sw);
    return OFF_SEL + k * sw;
  endfunction

  function automatic int off_ffuse(input int k,
                                   input int sw);
    return off_lut(k, sw) + (1 << k);
  endfunction

  function automatic int off_ffinit(input int k,
                                    input int sw);
    return off_ffuse(k, sw) + 1;
  endfunction

endpackage

// File: rtl/clb_ble.sv
// One BLE: input crossbar, LUT_K-input LUT and optional output flop.
// Ports: clk, reset, cfg_done, cfg slice, clb_I, ble_q in; lut, q, ff_use out.
module clb_ble
  import clb_pkg::*;
#(
  parameter int NUM_IN   = 10,
  parameter int NUM_BLE  = 4,
  parameter int LUT_K    = 4,
  parameter int SEL_W    = 4,
  parameter int BLE_BITS = 34
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_done,
  input  logic [BLE_BITS-1:0] cfg,
  input  logic [NUM_IN-1:0]   clb_I,
  input  logic [NUM_BLE-1:0]  ble_q,
  output logic                lut,
  output logic                q,
  output logic                ff_use
);

  localparam int OFF_L = off_lut(LUT_K, SEL_W);
  localparam int OFF_U = off_ffuse(LUT_K, SEL_W);
  localparam int OFF_I = off_ffinit(LUT_K, SEL_W);
  localparam int NSRC  = NUM_IN + NUM_BLE;

  // Sources padded to the full select range so that
  // out-of-range selects read a constant 0.
  logic [(2**SEL_W)-1:0] src;
  logic [LUT_K-1:0]      pin;
  logic [(2**LUT_K)-1:0] tt;
  logic                  ff_init;

  always_comb begin
    src = '0;
    src[NSRC-1:0] = {ble_q, clb_I};
  end

  for (genvar i = 0; i < LUT_K; i++) begin : g_pin
    logic [SEL_W-1:0] sel;
    assign sel    = cfg[OFF_SEL + i*SEL_W +: SEL_W];
    assign pin[i] = src[sel];
  end

  assign tt      = cfg[OFF_L +: 2**LUT_K];
  assign ff_use  = cfg[OFF_U];
  assign ff_init = cfg[OFF_I];
  assign lut     = tt[pin];

  always_ff @(posedge clk) begin
    if (reset)
      q <= 1'b0;
    else if (!cfg_done)
      q <= ff_init;
    else
      q <= lut;
  end

endmodule

// File: rtl/grid_clb_nk.sv
// CLB tile of NUM_BLE BLEs with a serial config chain and done flag.
// Ports: clk, reset, ccff_en/head in, ccff_tail, cfg_done out, clb_I in, clb_O out.
module grid_clb_nk
  import clb_pkg::*;
#(
  parameter int NUM_IN  = 10,
  parameter int NUM_BLE = 4,
  parameter int LUT_K   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ccff_en,
  input  logic               ccff_head,
  output logic               ccff_tail,
  output logic               cfg_done,
  input  logic [NUM_IN-1:0]  clb_I,
  output logic [NUM_BLE-1:0] clb_O
);

  localparam int SEL_W    = sel_w(NUM_IN, NUM_BLE);
  localparam int BLE_BITS = ble_bits(LUT_K, SEL_W);
  localparam int CFG_BITS = cfg_bits(NUM_BLE, BLE_BITS);
  localparam int CW       = clog2(CFG_BITS + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(CFG_BITS);

  logic [CFG_BITS-1:0] cfg;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_next;
  logic                done_next;
  logic [NUM_BLE-1:0]  ble_q;
  logic [NUM_BLE-1:0]  lut;
  logic [NUM_BLE-1:0]  ff_use;

  // A shift while loaded opens a new session at count 1.
  always_comb begin
    cnt_next = cnt;
    if (ccff_en) begin
      if (cfg_done)
        cnt_next = CW'(1);
      else if (cnt != CNT_MAX)
        cnt_next = cnt + CW'(1);
    end
    done_next = (cnt_next == CNT_MAX) && !ccff_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg      <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
    end else begin
      if (ccff_en)
        cfg <= {cfg[CFG_BITS-2:0], ccff_head};
      cnt      <= cnt_next;
      cfg_done <= done_next;
    end
  end

  assign ccff_tail = cfg[CFG_BITS-1];

  for (genvar b = 0; b < NUM_BLE; b++) begin : g_ble
    clb_ble #(
      .NUM_IN  (NUM_IN),
      .NUM_BLE (NUM_BLE),
      .LUT_K   (LUT_K),
      .SEL_W   (SEL_W),
      .BLE_BITS(BLE_BITS)
    ) u_ble (
      .clk     (clk),
      .reset   (reset),
      .cfg_done(cfg_done),
      .cfg     (cfg[b*BLE_BITS +: BLE_BITS]),
      .clb_I   (clb_I),
      .ble_q   (ble_q),
      .lut     (lut[b]),
      .q       (ble_q[b]),
      .ff_use  (ff_use[b])
    );
  end

  // Outputs stay quiet until a complete configuration is in place.
  assign clb_O = cfg_done ?
    ((ff_use & ble_q) | (~ff_use & lut)) : '0;

endmodule

// File: tb/tb_grid_clb_nk.sv
// Self-checking bench for grid_clb_nk at default parameters.
// Compares DUT against a bit-list reference model of the tile.
module tb_grid_clb_nk;

  localparam int NI = 10;
  localparam int NB = 4;
  localparam int K  = 4;
  localparam int SW = 4;
  localparam int BB = 34;
  localparam int CB = 136;

  logic          clk = 1'b0;
  logic          reset;
  logic          ccff_en;
  logic          ccff_head;
  logic [NI-1:0] clb_I;
  wire           ccff_tail;
  wire           cfg_done;
  wire  [NB-1:0] clb_O;

  always #5 clk = ~clk;

  grid_clb_nk dut (
    .clk      (clk),
    .reset    (reset),
    .ccff_en  (ccff_en),
    .ccff_head(ccff_head),
    .ccff_tail(ccff_tail),
    .cfg_done (cfg_done),
    .clb_I    (clb_I),
    .clb_O    (clb_O)
  );

  int vectors = 0;
  int errors  = 0;

  // Model: list of bits shifted in (newest last), flops, done flag.
  bit mbits[$];
  bit mq[NB];
  bit mdone;
  int mcnt;

  logic [CB-1:0] and4_cfg;
  logic [CB-1:0] tog_cfg;

  function automatic bit mcfg(int i);
    int idx;
    idx = mbits.size() - 1 - i;
    if (idx >= 0) return mbits[idx];
    return 1'b0;
  endfunction

  function automatic int fld(int b, int off, int w);
    int v;
    v = 0;
    for (int i = 0; i < w; i++)
      v = v | (int'(mcfg(b*BB + off + i)) << i);
    return v;
  endfunction

  function automatic bit m_lut(int b);
    int idx;
    int s;
    bit v;
    idx = 0;
    for (int i = 0; i < K; i++) begin
      s = fld(b, i*SW, SW);
      if (s < NI) v = clb_I[s];
      else if (s < NI + NB) v = mq[s-NI];
      else v = 1'b0;
      idx = idx | (int'(v) << i);
    end
    return mcfg(b*BB + K*SW + idx);
  endfunction

  function automatic logic [NB-1:0] m_out();
    logic [NB-1:0] o;
    o = '0;
    for (int b = 0; b < NB; b++)
      if (mdone)
        o[b] = (fld(b, K*SW+16, 1) != 0) ? mq[b] : m_lut(b);
    return o;
  endfunction

  function automatic bit m_tail();
    if (mbits.size() >= CB) return mbits[mbits.size()-CB];
    return 1'b0;
  endfunction

  function automatic logic [CB-1:0] ble_cfg(
    int b, int s0, int s1, int s2, int s3,
    logic [15:0] tt, bit fu, bit fi);
    logic [BB-1:0] v;
    logic [CB-1:0] w;
    v = {fi, fu, tt, 4'(s3), 4'(s2), 4'(s1), 4'(s0)};
    w = CB'(v);
    return w << (b*BB);
  endfunction

  task automatic tick();
    bit nq[NB];
    if (reset) begin
      mbits.delete();
      mcnt  = 0;
      mdone = 1'b0;
      for (int b = 0; b < NB; b++) mq[b] = 1'b0;
    end else begin
      for (int b = 0; b < NB; b++)
        nq[b] = mdone ? m_lut(b) : (fld(b, K*SW+17, 1) != 0);
      if (ccff_en) begin
        mbits.push_back(ccff_head);
        if (mbits.size() > CB) void'(mbits.pop_front());
        mcnt = mdone ? 1 : ((mcnt < CB) ? mcnt + 1 : CB);
      end
      mdone = (mcnt == CB) && !ccff_en;
      mq = nq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic shift_cfg(logic [CB-1:0] vec);
    for (int i = CB-1; i >= 0; i--) begin
      ccff_en   = 1'b1;
      ccff_head = vec[i];
      tick();
    end
    ccff_en = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    ccff_en = 1'b1;
    clb_I   = NI'($urandom);
    for (int i = 0; i < 2; i++) begin
      ccff_head = 1'($urandom);
      tick();
    end
    vectors++;
    if (ccff_tail !== 1'b0) begin
      errors++;
      $display("FAIL reset_tail got=%b exp=0", ccff_tail);
    end
    vectors++;
    if (cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b exp=0", cfg_done);
    end
    vectors++;
    if (clb_O !== '0) begin
      errors++;
      $display("FAIL reset_out got=%b exp=0000", clb_O);
    end
    reset   = 1'b0;
    ccff_en = 1'b0;
  endtask

  task automatic test_and4();
    logic [NB-1:0] exp;
    shift_cfg(and4_cfg);
    vectors++;
    if (cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL and4_done_early got=%b exp=0", cfg_done);
    end
    tick();
    vectors++;
    if (cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL and4_done got=%b exp=1", cfg_done);
    end
    clb_I = {6'($urandom), 4'hF};
    #1;
    vectors++;
    if (clb_O !== 4'b0001) begin
      errors++;
      $display("FAIL and4_F got=%b exp=0001", clb_O);
    end
    clb_I = {6'($urandom), 4'hE};
    #1;
    vectors++;
    if (clb_O !== 4'b0000) begin
      errors++;
      $display("FAIL and4_E got=%b exp=0000", clb_O);
    end
    for (int i = 0; i < 16; i++) begin
      clb_I = NI'($urandom);
      if (i % 4 == 0) clb_I[3:0] = 4'hF;
      #1;
      exp = {3'b000, &clb_I[3:0]};
      vectors++;
      if (clb_O !== exp || clb_O !== m_out()) begin
        errors++;
        $display("FAIL and4_rand I=%h got=%b exp=%b",
                 clb_I, clb_O, exp);
      end
      tick();
    end
  endtask

  task automatic test_toggle();
    logic exp;
    shift_cfg(tog_cfg);
    tick();
    for (int c = 0; c < 6; c++) begin
      clb_I = NI'($urandom);
      #1;
      exp = (c % 2 == 0);
      vectors++;
      if (clb_O[1] !== exp || clb_O !== m_out()) begin
        errors++;
        $display("FAIL toggle c=%0d got=%b exp_bit1=%b model=%b",
                 c, clb_O, exp, m_out());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_shift();
    for (int i = CB-1; i >= CB-70; i--) begin
      ccff_en   = 1'b1;
      ccff_head = and4_cfg[i];
      tick();
    end
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    ccff_en = 1'b0;
    vectors++;
    if (cfg_done !== 1'b0 || ccff_tail !== 1'b0 ||
        clb_O !== '0) begin
      errors++;
      $display("FAIL midrst_state done=%b tail=%b out=%b exp=0,0,0",
               cfg_done, ccff_tail, clb_O);
    end
    shift_cfg(and4_cfg);
    vectors++;
    if (cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_done_early got=%b exp=0", cfg_done);
    end
    tick();
    vectors++;
    if (cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL midrst_done got=%b exp=1", cfg_done);
    end
    clb_I = {6'($urandom), 4'hF};
    #1;
    vectors++;
    if (clb_O !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_F got=%b exp=0001", clb_O);
    end
    clb_I = {6'($urandom), 4'hE};
    #1;
    vectors++;
    if (clb_O !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_E got=%b exp=0000", clb_O);
    end
  endtask

  task automatic test_chain();
    bit rb[2*CB];
    bit exp;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 2*CB; n++) begin
      rb[n]     = 1'($urandom);
      ccff_en   = 1'b1;
      ccff_head = rb[n];
      tick();
      exp = (n >= CB-1) ? rb[n-CB+1] : 1'b0;
      vectors++;
      if (ccff_tail !== exp) begin
        errors++;
        $display("FAIL chain_tail n=%0d got=%b exp=%b",
                 n, ccff_tail, exp);
      end
    end
    ccff_en = 1'b0;
    tick();
    vectors++;
    if (cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL chain_done got=%b exp=1", cfg_done);
    end
    clb_I = NI'($urandom);
    #1;
    vectors++;
    if (clb_O !== m_out()) begin
      errors++;
      $display("FAIL chain_out got=%b exp=%b", clb_O, m_out());
    end
  endtask

  task automatic test_reconfig();
    shift_cfg(and4_cfg);
    tick();
    clb_I = {6'($urandom), 4'hF};
    #1;
    vectors++;
    if (clb_O !== 4'b0001) begin
      errors++;
      $display("FAIL reconf_pre got=%b exp=0001", clb_O);
    end
    ccff_en   = 1'b1;
    ccff_head = 1'($urandom);
    tick();
    ccff_en = 1'b0;
    vectors++;
    if (cfg_done !== 1'b0 || clb_O !== '0) begin
      errors++;
      $display("FAIL reconf_drop done=%b out=%b exp=0,0000",
               cfg_done, clb_O);
    end
    for (int i = 0; i < 134; i++) begin
      ccff_en   = 1'b1;
      ccff_head = 1'($urandom);
      tick();
    end
    ccff_en = 1'b0;
    tick();
    vectors++;
    if (cfg_done !== 1'b0 || clb_O !== '0) begin
      errors++;
      $display("FAIL reconf_135 done=%b out=%b exp=0,0000",
               cfg_done, clb_O);
    end
    ccff_en   = 1'b1;
    ccff_head = 1'($urandom);
    tick();
    ccff_en = 1'b0;
    tick();
    vectors++;
    if (cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL reconf_done got=%b exp=1", cfg_done);
    end
    vectors++;
    if (clb_O !== m_out()) begin
      errors++;
      $display("FAIL reconf_out got=%b exp=%b", clb_O, m_out());
    end
  endtask

  task automatic test_random_cfg();
    logic [CB-1:0] vec;
    for (int r = 0; r < 6; r++) begin
      vec = '0;
      for (int b = 0; b < NB; b++)
        vec = vec | ble_cfg(b,
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          16'($urandom), 1'($urandom), 1'($urandom));
      shift_cfg(vec);
      tick();
      for (int c = 0; c < 25; c++) begin
        clb_I = NI'($urandom);
        #1;
        vectors++;
        if (clb_O !== m_out() || ccff_tail !== m_tail()) begin
          errors++;
          $display("FAIL rand r=%0d c=%0d out=%b exp=%b tail=%b exp=%b",
                   r, c, clb_O, m_out(), ccff_tail, m_tail());
        end
        tick();
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    clb_I     = '0;
    and4_cfg  = ble_cfg(0, 0, 1, 2, 3, 16'h8000, 1'b0, 1'b0);
    tog_cfg   = ble_cfg(1, 11, 0, 0, 0, 16'h5555, 1'b1, 1'b1);
    test_reset();
    test_and4();
    test_toggle();
    test_reset_mid_shift();
    test_chain();
    test_reconfig();
    test_random_cfg();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
